// File: rtl/periph_bus_bridge_if.sv
// Core data port, slave bus and error signals of the peripheral bridge.
// The slave modport is the bridge's view; master is the core/slave side.
interface periph_bus_bridge_if #(
  parameter int N = 4
);
  logic          m_req_i;
  logic          m_we_i;
  logic [31:0]   m_addr_i;
  logic [31:0]   m_wdata_i;
  logic [3:0]    m_wmask_i;
  logic [31:0]   m_rdata_o;
  logic          m_rvalid_o;
  logic [N-1:0]  s_csb_o;
  logic          s_we_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic [3:0]    s_wmask_o;
  logic [N*32-1:0] s_rdata_i;
  logic          err_pulse_o;
  logic          err_sticky_o;
  logic [31:0]   err_addr_o;
  logic          err_clr_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i,
    input  m_wdata_i, m_wmask_i,
    input  s_rdata_i, err_clr_i,
    output m_rdata_o, m_rvalid_o,
    output s_csb_o, s_we_o, s_addr_o,
    output s_wdata_o, s_wmask_o,
    output err_pulse_o, err_sticky_o,
    output err_addr_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i,
    output m_wdata_i, m_wmask_i,
    output s_rdata_i, err_clr_i,
    input  m_rdata_o, m_rvalid_o,
    input  s_csb_o, s_we_o, s_addr_o,
    input  s_wdata_o, s_wmask_o,
    input  err_pulse_o, err_sticky_o,
    input  err_addr_o
  );
endinterface

// File: rtl/periph_bus_bridge.sv
// Core data port to N-window peripheral bridge with registered request,
// latency-aligned read mux and sticky unmapped-access error capture.
module periph_bus_bridge #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE =
    {32'h0000_8200, 32'h0000_8100,
     32'h0000_8000, 32'h0000_8010},
  parameter logic [NUM_SLAVES*8-1:0] SLV_SIZE_LG2 =
    {8'd8, 8'd8, 8'd4, 8'd2},
  parameter int RD_LAT = 0,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input logic clk_i,
  input logic reset_i,
  periph_bus_bridge_if.slave bus
);
  localparam int N = NUM_SLAVES;

  logic [N-1:0] w_hit;
  logic [N-1:0] w_sel;
  logic         w_found;
  logic         w_map;
  logic         w_rd_req;

  logic [N-1:0] r_csb;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic [3:0]   r_wmask;
  logic         r_rd;
  logic         r_err_rd;
  logic [N-1:0] r_sel;
  logic         r_errp;
  logic         r_sticky;
  logic [31:0]  r_eaddr;

  logic         r2_rd;
  logic         r2_err_rd;
  logic [N-1:0] r2_sel;

  logic         w_vld;
  logic         w_err;
  logic [N-1:0] w_osel;
  logic [31:0]  w_rdata;
  logic [31:0]  r_rdata;

  // Window match on the aligned upper bits; lowest index wins.
  always_comb begin
    w_hit   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_hit[k] =
        (bus.m_addr_i >> SLV_SIZE_LG2[k*8 +: 8]) ==
        (SLV_BASE[k*32 +: 32] >> SLV_SIZE_LG2[k*8 +: 8]);
      w_sel[k] = w_hit[k] & ~w_found;
      w_found  = w_found | w_hit[k];
    end
  end

  assign w_map    = |w_hit;
  assign w_rd_req = bus.m_req_i & ~bus.m_we_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_csb    <= '1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_rd     <= 1'b0;
      r_err_rd <= 1'b0;
      r_sel    <= '0;
      r_errp   <= 1'b0;
      r_sticky <= 1'b0;
      r_eaddr  <= '0;
    end else begin
      r_csb    <= bus.m_req_i ? ~w_sel : '1;
      r_rd     <= w_rd_req;
      r_err_rd <= w_rd_req & ~w_map;
      r_sel    <= w_rd_req ? w_sel : '0;
      r_errp   <= bus.m_req_i & ~w_map;
      if (bus.m_req_i) begin
        r_we    <= bus.m_we_i;
        r_addr  <= bus.m_addr_i;
        r_wdata <= bus.m_wdata_i;
        r_wmask <= bus.m_wmask_i;
      end
      // A new error beats a clear in the same cycle.
      if (bus.m_req_i && !w_map) begin
        r_sticky <= 1'b1;
        if (!r_sticky || bus.err_clr_i)
          r_eaddr <= bus.m_addr_i;
      end else if (bus.err_clr_i) begin
        r_sticky <= 1'b0;
        r_eaddr  <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r2_rd     <= 1'b0;
      r2_err_rd <= 1'b0;
      r2_sel    <= '0;
    end else begin
      r2_rd     <= r_rd;
      r2_err_rd <= r_err_rd;
      r2_sel    <= r_sel;
    end
  end

  assign w_vld  = (RD_LAT != 0) ? r2_rd     : r_rd;
  assign w_err  = (RD_LAT != 0) ? r2_err_rd : r_err_rd;
  assign w_osel = (RD_LAT != 0) ? r2_sel    : r_sel;

  always_comb begin
    w_rdata = '0;
    if (w_err) begin
      w_rdata = ERR_RDATA;
    end else begin
      for (int k = 0; k < N; k++)
        if (w_osel[k])
          w_rdata = w_rdata | bus.s_rdata_i[k*32 +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_rdata <= '0;
    else if (w_vld)
      r_rdata <= w_rdata;
  end

  assign bus.m_rvalid_o   = w_vld;
  assign bus.m_rdata_o    = w_vld ? w_rdata : r_rdata;
  assign bus.s_csb_o      = r_csb;
  assign bus.s_we_o       = r_we;
  assign bus.s_addr_o     = r_addr;
  assign bus.s_wdata_o    = r_wdata;
  assign bus.s_wmask_o    = r_wmask;
  assign bus.err_pulse_o  = r_errp;
  assign bus.err_sticky_o = r_sticky;
  assign bus.err_addr_o   = r_eaddr;
endmodule
